// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [3:0]            dmem_be;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane select followed by extension according to access type
  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory requests, formats stores,
// aligns loads and stalls the pipeline while a transaction is outstanding.
module mem_stage_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_MemRead,
  input  logic                  mem_MemWrite,
  input  logic [2:0]            mem_funct3,
  input  logic [ADDR_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_rs2_data,
  output logic                  lsu_stall,
  mem_stage_lsu_if.master       dmem,
  output logic [DATA_WIDTH-1:0] wb_load_data,
  output logic                  lsu_fault,
  output logic                  lsu_timeout
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t            state;
  logic [7:0]            tcnt;
  logic [DATA_WIDTH-1:0] load_q;

  logic                  is_load;
  logic                  is_store;
  logic                  f3_legal;
  logic                  aligned;
  logic                  access_ok;
  logic                  drive;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] aligned_rdata;

  lsu_load_align u_align (
    .rdata     (dmem.dmem_rdata),
    .addr_lo   (mem_alu_result[1:0]),
    .funct3    (mem_funct3),
    .load_data (aligned_rdata)
  );

  // Access decode: legality, alignment and store formatting
  always_comb begin
    is_load  = mem_MemRead & ~mem_MemWrite;
    is_store = mem_MemWrite & ~mem_MemRead;

    f3_legal = 1'b0;
    if (is_load)
      f3_legal = (mem_funct3 == F3_B) || (mem_funct3 == F3_H) || (mem_funct3 == F3_W) ||
                 (mem_funct3 == F3_BU) || (mem_funct3 == F3_HU);
    else if (is_store)
      f3_legal = (mem_funct3 == F3_B) || (mem_funct3 == F3_H) || (mem_funct3 == F3_W);

    case (mem_funct3[1:0])
      2'b01:   aligned = ~mem_alu_result[0];
      2'b10:   aligned = (mem_alu_result[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    access_ok = f3_legal & aligned;

    case (mem_funct3[1:0])
      2'b00: begin
        st_wdata = {4{mem_rs2_data[7:0]}};
        st_be    = 4'b0001 << mem_alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{mem_rs2_data[15:0]}};
        st_be    = 4'b0011 << mem_alu_result[1:0];
      end
      default: begin
        st_wdata = mem_rs2_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Output drive; everything is forced low while reset is asserted
  always_comb begin
    drive       = ~rst & access_ok;
    timeout_hit = (((state == REQ) & ~dmem.dmem_gnt) | ((state == WAIT) & ~dmem.dmem_rvalid)) &
                  (tcnt == TO_LAST);

    dmem.dmem_req   = drive & ((state == IDLE) | (state == REQ));
    dmem.dmem_we    = drive & is_store;
    dmem.dmem_addr  = drive ? mem_alu_result : '0;
    dmem.dmem_wdata = (drive & is_store) ? st_wdata : '0;
    dmem.dmem_be    = drive ? (is_store ? st_be : 4'b1111) : 4'b0000;

    lsu_stall    = drive & (state != DONE);
    lsu_fault    = ~rst & (mem_MemRead | mem_MemWrite) & ~access_ok;
    lsu_timeout  = ~rst & timeout_hit;
    wb_load_data = (~rst & (state == DONE)) ? load_q : '0;
  end

  // Transaction FSM with timeout counter and captured load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      load_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (access_ok) begin
            load_q <= '0;
            if (dmem.dmem_gnt) state <= is_store ? DONE : WAIT;
            else               state <= REQ;
          end
        end
        REQ: begin
          tcnt <= tcnt + 8'd1;
          if (dmem.dmem_gnt) begin
            state <= is_store ? DONE : WAIT;
          end else if (timeout_hit) begin
            load_q <= '0;
            state  <= DONE;
          end
        end
        WAIT: begin
          tcnt <= tcnt + 8'd1;
          if (dmem.dmem_rvalid) begin
            load_q <= aligned_rdata;
            state  <= DONE;
          end else if (timeout_hit) begin
            load_q <= '0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
